// File: rtl/psum_bram_arbiter_pkg.sv
// Shared types and constants for the psum BRAM arbiter: return-path source
// tags, arbitration slot encodings and the default psum bus widths.
package psum_bram_arbiter_pkg;

    localparam int PSUM_ADDR_WIDTH = 32;
    localparam int PSUM_DATA_WIDTH = 32;

    // Who owns the data coming out of the return pipeline.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CORE = 2'd1,
        SRC_HOST = 2'd2,
        SRC_FWD  = 2'd3
    } src_e;

    // Which requester owns the BRAM port this cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_RD    = 2'd1,
        SLOT_DRAIN = 2'd2,
        SLOT_HOST  = 2'd3
    } slot_e;

    // Forwarded reads and BRAM reads both answer the core.
    function automatic logic src_is_core(input src_e s);
        return (s == SRC_CORE) || (s == SRC_FWD);
    endfunction

endpackage

// File: rtl/psum_bram_arbiter_if.sv
// Bus bundle for the psum arbiter: core read/write port, host readback port
// and the single-port BRAM side. slave = arbiter view, master = environment.
interface psum_bram_arbiter_if #(
    parameter int ADDR_WIDTH = psum_bram_arbiter_pkg::PSUM_ADDR_WIDTH,
    parameter int DATA_WIDTH = psum_bram_arbiter_pkg::PSUM_DATA_WIDTH
);
    // core side (memctrl0_*)
    logic                  i_rd_en;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic [DATA_WIDTH-1:0] o_rd_dat;
    logic                  o_rd_val;
    logic                  i_wr_en;
    logic [ADDR_WIDTH-1:0] i_wr_addr;
    logic [DATA_WIDTH-1:0] i_wr_dat;
    logic                  o_core_stall;
    logic                  o_wr_drop_err;
    // host readback side
    logic                  i_host_req;
    logic [ADDR_WIDTH-1:0] i_host_addr;
    logic                  o_host_gnt;
    logic [DATA_WIDTH-1:0] o_host_dat;
    logic                  o_host_val;
    // BRAM side
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_idat;
    logic                  o_mem_wren;
    logic                  o_mem_enb;
    logic [DATA_WIDTH-1:0] i_mem_odat;

    modport slave (
        input  i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_dat,
        input  i_host_req, i_host_addr, i_mem_odat,
        output o_rd_dat, o_rd_val, o_core_stall, o_wr_drop_err,
        output o_host_gnt, o_host_dat, o_host_val,
        output o_mem_addr, o_mem_idat, o_mem_wren, o_mem_enb
    );

    modport master (
        output i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_dat,
        output i_host_req, i_host_addr, i_mem_odat,
        input  o_rd_dat, o_rd_val, o_core_stall, o_wr_drop_err,
        input  o_host_gnt, o_host_dat, o_host_val,
        input  o_mem_addr, o_mem_idat, o_mem_wren, o_mem_enb
    );

endinterface

// File: rtl/psum_bram_arbiter_wr_fifo.sv
// Circular core-write buffer with a parallel address lookup that returns the
// youngest pending entry for a given address (read-after-write forwarding).
module psum_wr_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic                  empty,
    output logic                  almost_full,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_dat,
    output logic                  drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] dat_mem  [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  drop_err_reg;

    logic full;
    logic push_ok;
    logic pop_ok;
    logic [DEPTH-1:0] match;

    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= CW'(DEPTH - 1));
    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign head_addr   = addr_mem[rd_ptr_reg];
    assign head_dat    = dat_mem[rd_ptr_reg];
    assign drop_err    = drop_err_reg;

    // Entry storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            dat_mem[wr_ptr_reg]  <= push_dat;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_err_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
            if (push && full) drop_err_reg <= 1'b1;
        end
    end

    // Per-slot compare: a slot is live when its distance from the head is
    // below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        logic [PW-1:0] age;
        assign age       = PW'(gi) - rd_ptr_reg;
        assign match[gi] = (CW'(age) < count_reg) && (addr_mem[gi] == lookup_addr);
    end

    // Walk from oldest to youngest so the last hit (youngest) wins.
    always_comb begin
        hit     = 1'b0;
        hit_dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[rd_ptr_reg + PW'(k)]) begin
                hit     = 1'b1;
                hit_dat = dat_mem[rd_ptr_reg + PW'(k)];
            end
        end
    end

endmodule

// File: rtl/psum_bram_arbiter.sv
// Shares one single-port psum BRAM between core reads, buffered core writes
// and host readback. Core reads have priority; an aged host request forces a
// stall so readback cannot be starved. Return data is routed by a tag
// pipeline matched to the BRAM latency so all reads answer at 1+MEM_LAT.
module psum_bram_arbiter
    import psum_bram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = PSUM_ADDR_WIDTH,
    parameter int DATA_WIDTH    = PSUM_DATA_WIDTH,
    parameter int MEM_LAT       = 1,
    parameter int WFIFO_DEPTH   = 4,
    parameter int HOST_MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    psum_bram_arbiter_if.slave bus
);

    localparam int AGE_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(HOST_MAX_WAIT);

    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_dat;
    logic                  fifo_empty;
    logic                  fifo_afull;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_dat;
    logic                  drop_err;

    logic [AGE_W-1:0]      age_reg;
    logic                  force_host;
    logic                  host_gnt;
    slot_e                 slot;
    src_e                  tag_src_in;
    src_e                  tag_src_out;
    logic [DATA_WIDTH-1:0] tag_dat_out;

    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_idat_reg;
    logic                  mem_wren_reg;
    logic                  mem_enb_reg;

    psum_wr_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (bus.i_wr_en),
        .push_addr   (bus.i_wr_addr),
        .push_dat    (bus.i_wr_dat),
        .pop         (slot == SLOT_DRAIN),
        .head_addr   (head_addr),
        .head_dat    (head_dat),
        .empty       (fifo_empty),
        .almost_full (fifo_afull),
        .lookup_addr (bus.i_rd_addr),
        .hit         (fwd_hit),
        .hit_dat     (fwd_dat),
        .drop_err    (drop_err)
    );

    assign force_host = (age_reg == AGE_MAX);

    // Slot choice: BRAM-bound core read, then drain vs host (host first once aged).
    always_comb begin
        slot = SLOT_IDLE;
        if (bus.i_rd_en && !fwd_hit)           slot = SLOT_RD;
        else if (force_host && bus.i_host_req) slot = SLOT_HOST;
        else if (!fifo_empty)                  slot = SLOT_DRAIN;
        else if (bus.i_host_req)               slot = SLOT_HOST;
    end

    assign host_gnt = (slot == SLOT_HOST) && !rst;

    // Tag entering the return pipeline; forwarded reads carry their data along.
    always_comb begin
        tag_src_in = SRC_NONE;
        if (bus.i_rd_en)              tag_src_in = fwd_hit ? SRC_FWD : SRC_CORE;
        else if (slot == SLOT_HOST)   tag_src_in = SRC_HOST;
    end

    // Host age counter: counts ungranted waiting cycles, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_reg <= '0;
        end else if (!bus.i_host_req || host_gnt) begin
            age_reg <= '0;
        end else if (age_reg != AGE_MAX) begin
            age_reg <= age_reg + 1'b1;
        end
    end

    // Registered BRAM command for the winning slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_reg <= '0;
            mem_idat_reg <= '0;
            mem_wren_reg <= 1'b0;
            mem_enb_reg  <= 1'b0;
        end else begin
            mem_enb_reg  <= (slot != SLOT_IDLE);
            mem_wren_reg <= (slot == SLOT_DRAIN);
            case (slot)
                SLOT_RD:    mem_addr_reg <= bus.i_rd_addr;
                SLOT_HOST:  mem_addr_reg <= bus.i_host_addr;
                SLOT_DRAIN: begin
                    mem_addr_reg <= head_addr;
                    mem_idat_reg <= head_dat;
                end
                default:    ;
            endcase
        end
    end

    // Tag/data delay line, one stage per cycle of total read latency.
    for (genvar gi = 0; gi <= MEM_LAT; gi++) begin : g_tag
        src_e                  src_prev;
        logic [DATA_WIDTH-1:0] dat_prev;
        src_e                  src_reg;
        logic [DATA_WIDTH-1:0] dat_reg;

        if (gi == 0) begin : g_in
            assign src_prev = tag_src_in;
            assign dat_prev = fwd_dat;
        end else begin : g_chain
            assign src_prev = g_tag[gi-1].src_reg;
            assign dat_prev = g_tag[gi-1].dat_reg;
        end

        // Shift one stage; reset discards in-flight reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                src_reg <= SRC_NONE;
                dat_reg <= '0;
            end else begin
                src_reg <= src_prev;
                dat_reg <= dat_prev;
            end
        end
    end

    assign tag_src_out = g_tag[MEM_LAT].src_reg;
    assign tag_dat_out = g_tag[MEM_LAT].dat_reg;

    assign bus.o_rd_val      = !rst && src_is_core(tag_src_out);
    assign bus.o_rd_dat      = !bus.o_rd_val ? '0 :
                               (tag_src_out == SRC_FWD) ? tag_dat_out : bus.i_mem_odat;
    assign bus.o_host_val    = !rst && (tag_src_out == SRC_HOST);
    assign bus.o_host_dat    = bus.o_host_val ? bus.i_mem_odat : '0;
    assign bus.o_host_gnt    = host_gnt;
    assign bus.o_core_stall  = !rst && (force_host || fifo_afull);
    assign bus.o_wr_drop_err = drop_err;
    assign bus.o_mem_addr    = mem_addr_reg;
    assign bus.o_mem_idat    = mem_idat_reg;
    assign bus.o_mem_wren    = mem_wren_reg;
    assign bus.o_mem_enb     = mem_enb_reg;

endmodule

// File: tb/tb_psum_bram_arbiter.sv
// Directed + randomized bench for psum_bram_arbiter. A logical memory model
// predicts every core/host read value and its arrival cycle (2 cycles after
// request/grant); an external BRAM model with one cycle read latency serves
// the DUT's memory port.
module tb_psum_bram_arbiter;

    localparam int HMW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psum_bram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    psum_bram_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MEM_LAT       (1),
        .WFIFO_DEPTH   (4),
        .HOST_MAX_WAIT (HMW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- external BRAM model ----------------
    logic [31:0] bram [0:511];
    logic [31:0] bram_odat = '0;
    assign bus.i_mem_odat = bram_odat;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, 16'hC0DE};
    endfunction

    always @(posedge clk) begin
        if (bus.o_mem_enb) begin
            if (bus.o_mem_wren) bram[bus.o_mem_addr[8:0]] <= bus.o_mem_idat;
            else                bram_odat <= bram[bus.o_mem_addr[8:0]];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        rd_q[$];
    exp_t        host_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_dat[$];
    int          mem_rd_cnt = 0;
    int          mem_wr_cnt = 0;
    int          host_wait  = 0;
    logic        stall_seen = 1'b0;
    logic        gnt_seen   = 1'b0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: sample at negedge, score, update model, then advance.
    task automatic step();
        @(negedge clk);
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            chk("rd_val", 32'(bus.o_rd_val), 32'd1);
            chk("rd_dat", bus.o_rd_dat, rd_q[0].dat);
            void'(rd_q.pop_front());
        end else begin
            chk("rd_val_idle", 32'(bus.o_rd_val), 32'd0);
        end
        if (host_q.size() > 0 && host_q[0].due == cyc) begin
            chk("host_val", 32'(bus.o_host_val), 32'd1);
            chk("host_dat", bus.o_host_dat, host_q[0].dat);
            void'(host_q.pop_front());
        end else begin
            chk("host_val_idle", 32'(bus.o_host_val), 32'd0);
        end
        chk("wr_drop_err", 32'(bus.o_wr_drop_err), 32'd0);
        if (bus.o_mem_enb) begin
            if (bus.o_mem_wren) begin
                wlog_addr.push_back(bus.o_mem_addr);
                wlog_dat.push_back(bus.o_mem_idat);
                mem_wr_cnt++;
            end else begin
                mem_rd_cnt++;
            end
        end
        stall_seen = bus.o_core_stall;
        gnt_seen   = bus.o_host_gnt;
        if (!rst && bus.i_host_req) begin
            if (bus.o_host_gnt) begin
                chk("host_wait_bound", 32'(host_wait <= HMW + 1), 32'd1);
                host_q.push_back('{cyc + 2, dflt(bus.i_host_addr)});
                host_wait = 0;
            end else begin
                host_wait++;
            end
        end else begin
            chk("host_gnt_idle", 32'(bus.o_host_gnt), 32'd0);
        end
        if (!rst && bus.i_rd_en) rd_q.push_back('{cyc + 2, ref_rd(bus.i_rd_addr)});
        if (!rst && bus.i_wr_en) ref_mem[bus.i_wr_addr] = bus.i_wr_dat;
        if (rst) begin
            rd_q.delete();
            host_q.delete();
            host_wait = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        bus.i_rd_en   = 1'b0;
        bus.i_wr_en   = 1'b0;
        bus.i_rd_addr = '0;
        bus.i_wr_addr = '0;
        bus.i_wr_dat  = '0;
    endtask

    initial begin
        int          base_w;
        int          base_r;
        int          first_stall;
        int          gnt_rel;
        logic [31:0] t5_addr [4];
        logic [31:0] t5_dat  [4];

        for (int i = 0; i < 512; i++) bram[i] = dflt(32'(i));
        core_idle();
        bus.i_host_req  = 1'b0;
        bus.i_host_addr = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // T1: idle after reset, everything stays quiet
        for (int i = 0; i < 10; i++) begin
            chk("t1_mem_enb",   32'(bus.o_mem_enb),    32'd0);
            chk("t1_mem_wren",  32'(bus.o_mem_wren),   32'd0);
            chk("t1_mem_addr",  bus.o_mem_addr,        32'd0);
            chk("t1_stall",     32'(bus.o_core_stall), 32'd0);
            chk("t1_rd_dat",    bus.o_rd_dat,          32'd0);
            chk("t1_host_dat",  bus.o_host_dat,        32'd0);
            step();
        end

        // T2: a single write drains to BRAM
        base_w = mem_wr_cnt;
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 32'h10; bus.i_wr_dat = 32'hAABB;
        step();
        core_idle();
        repeat (5) step();
        chk("t2_wr_count", 32'(mem_wr_cnt - base_w), 32'd1);
        chk("t2_wr_addr",  wlog_addr[$], 32'h10);
        chk("t2_wr_dat",   wlog_dat[$],  32'hAABB);
        chk("t2_stall",    32'(bus.o_core_stall), 32'd0);

        // T3: read right behind a write is forwarded, BRAM not read
        base_r = mem_rd_cnt;
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 32'h20; bus.i_wr_dat = 32'h1234;
        step();
        core_idle();
        bus.i_rd_en = 1'b1; bus.i_rd_addr = 32'h20;
        step();
        core_idle();
        repeat (4) step();
        chk("t3_no_mem_rd",  32'(mem_rd_cnt - base_r), 32'd0);
        chk("t3_rd_pending", 32'(rd_q.size()), 32'd0);

        // T4: continuous reads starve the host until the age limit forces a slot
        first_stall = -1;
        gnt_rel     = -1;
        stall_seen  = 1'b0;
        bus.i_host_req = 1'b1; bus.i_host_addr = 32'h5;
        for (int i = 0; i < 40; i++) begin
            bus.i_rd_en   = !stall_seen;
            bus.i_rd_addr = (i % 3 == 0) ? 32'h10 : 32'h40 + 32'($urandom_range(0, 15));
            step();
            if (stall_seen && first_stall < 0) first_stall = i;
            if (gnt_seen) begin
                gnt_rel = i;
                bus.i_host_req = 1'b0;
            end
        end
        core_idle();
        repeat (3) step();
        chk("t4_first_stall", 32'(first_stall), 32'(HMW));
        chk("t4_gnt_cycle",   32'(gnt_rel),     32'(HMW + 1));
        chk("t4_host_pending", 32'(host_q.size()), 32'd0);

        // T5: four back-to-back writes while reads hold the port
        base_w = wlog_addr.size();
        for (int i = 0; i < 4; i++) begin
            t5_addr[i] = 32'h30 + 32'(i);
            t5_dat[i]  = $urandom;
            bus.i_wr_en = 1'b1; bus.i_wr_addr = t5_addr[i]; bus.i_wr_dat = t5_dat[i];
            bus.i_rd_en = 1'b1; bus.i_rd_addr = 32'h48 + 32'(i);
            step();
            chk("t5_stall", 32'(stall_seen), (i == 3) ? 32'd1 : 32'd0);
        end
        core_idle();
        repeat (8) step();
        chk("t5_wr_count", 32'(wlog_addr.size() - base_w), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wlog_addr.size() >= base_w + 4) begin
                chk("t5_wr_addr", wlog_addr[base_w + i], t5_addr[i]);
                chk("t5_wr_dat",  wlog_dat[base_w + i],  t5_dat[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus.i_rd_en = 1'b1; bus.i_rd_addr = t5_addr[i];
            step();
        end
        core_idle();
        repeat (3) step();

        // T6: reset with reads in flight and a write pending
        base_w = mem_wr_cnt;
        bus.i_rd_en = 1'b1; bus.i_rd_addr = 32'h30;
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 32'h77; bus.i_wr_dat = 32'hDEAD;
        step();
        bus.i_wr_en = 1'b0;
        bus.i_rd_addr = 32'h31;
        rst = 1'b1;
        step();
        rst = 1'b0;
        core_idle();
        repeat (6) step();
        chk("t6_no_drain", 32'(mem_wr_cnt - base_w), 32'd0);
        chk("t6_stall",    32'(bus.o_core_stall),    32'd0);
        chk("t6_mem_enb",  32'(bus.o_mem_enb),       32'd0);

        // T7: randomized traffic from a core that honours stall
        stall_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.i_rd_en   = !stall_seen && ($urandom_range(0, 1) == 1);
            bus.i_rd_addr = 32'($urandom_range(0, 7));
            bus.i_wr_en   = !stall_seen && ($urandom_range(0, 2) == 0);
            bus.i_wr_addr = 32'($urandom_range(0, 7));
            bus.i_wr_dat  = $urandom;
            if (!bus.i_host_req && $urandom_range(0, 5) == 0) begin
                bus.i_host_req  = 1'b1;
                bus.i_host_addr = 32'h100 + 32'($urandom_range(0, 7));
            end
            step();
            if (gnt_seen) bus.i_host_req = 1'b0;
        end
        core_idle();
        bus.i_host_req = 1'b0;
        repeat (8) step();
        chk("t7_rd_pending",   32'(rd_q.size()),   32'd0);
        chk("t7_host_pending", 32'(host_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
